// File: rtl/rfc_pkg.sv
// rfc_pkg: shared definitions for the register-file micro-op sequencer.
//   - default operand/address widths
//   - opcode encoding (op_e)
//   - FSM state encoding (state_e)
//   - is_wb(): whether an opcode writes its result back
package rfc_pkg;

  localparam int RFC_DATA_W = 4;
  localparam int RFC_ADDR_W = 2;

  typedef enum logic [2:0] {
    OP_MOV = 3'b000,
    OP_LDI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  // CMP only produces flags; every other opcode writes the destination.
  function automatic logic is_wb(op_e op);
    return (op != OP_CMP);
  endfunction

endpackage

// File: rtl/rfc_alu.sv
// rfc_alu: combinational 4-function-class ALU for regfile_ctrl.
// Ports:
//   op   in  opcode (op_e)
//   a,b  in  DATA_W operands captured from the register file
//   imm  in  DATA_W immediate (LDI)
//   res  out DATA_W result, mod 2^DATA_W (CMP: the difference)
//   z    out result == 0
//   c    out ADD: carry-out; SUB/CMP: borrow (a < b unsigned); else 0
module rfc_alu
  import rfc_pkg::*;
#(
  parameter int DATA_W = RFC_DATA_W
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] res,
  output logic              z,
  output logic              c
);

  // One extra bit so carry and borrow fall out of the same top bit.
  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    c    = 1'b0;
    unique case (op)
      OP_MOV: wide = {1'b0, a};
      OP_LDI: wide = {1'b0, imm};
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        c    = wide[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        // Unsigned subtract wraps past zero exactly when a < b.
        wide = {1'b0, a} - {1'b0, b};
        c    = wide[DATA_W];
      end
      OP_AND: wide = {1'b0, a & b};
      OP_OR:  wide = {1'b0, a | b};
      OP_XOR: wide = {1'b0, a ^ b};
      default: wide = '0;
    endcase
    res = wide[DATA_W-1:0];
    z   = (res == '0);
  end

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: 4-cycle micro-op sequencer driving a 2-read/1-write register
// file. One instruction per IDLE->READ->EXEC->WRITE pass.
// Ports:
//   CLK, RST_N              clock, async active-low reset
//   IN_VALID/IN_READY       instruction handshake (ready only in IDLE)
//   IN_OP/DST/SRCA/SRCB/IMM instruction fields
//   Aaddr, Baddr / Adata, Bdata   register-file read ports
//   WR, Daddr, Ddata        register-file write port
//   BUSY                    any state but IDLE
//   DONE                    one-cycle pulse in WRITE
//   FLAG_Z, FLAG_C          flags of the last executed instruction
// All outputs are registered except IN_READY and BUSY (state decodes).
module regfile_ctrl
  import rfc_pkg::*;
#(
  parameter int DATA_W = RFC_DATA_W,
  parameter int ADDR_W = RFC_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [2:0]        IN_OP,
  input  logic [ADDR_W-1:0] IN_DST,
  input  logic [ADDR_W-1:0] IN_SRCA,
  input  logic [ADDR_W-1:0] IN_SRCB,
  input  logic [DATA_W-1:0] IN_IMM,
  output logic [ADDR_W-1:0] Aaddr,
  output logic [ADDR_W-1:0] Baddr,
  input  logic [DATA_W-1:0] Adata,
  input  logic [DATA_W-1:0] Bdata,
  output logic              WR,
  output logic [ADDR_W-1:0] Daddr,
  output logic [DATA_W-1:0] Ddata,
  output logic              BUSY,
  output logic              DONE,
  output logic              FLAG_Z,
  output logic              FLAG_C
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [ADDR_W-1:0]   aaddr_q, aaddr_d;
  logic [ADDR_W-1:0]   baddr_q, baddr_d;
  logic                wr_q, wr_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   daddr_q, daddr_d;
  logic [DATA_W-1:0]   ddata_q, ddata_d;
  logic                fz_q, fz_d;
  logic                fc_q, fc_d;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_z, alu_c;

  rfc_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (op_q),
    .a   (opa_q),
    .b   (opb_q),
    .imm (imm_q),
    .res (alu_res),
    .z   (alu_z),
    .c   (alu_c)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    aaddr_d = aaddr_q;
    baddr_d = baddr_q;
    daddr_d = daddr_q;
    ddata_d = ddata_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          op_d    = op_e'(IN_OP);
          dst_d   = IN_DST;
          imm_d   = IN_IMM;
          // Read addresses load at accept so they are already stable in READ;
          // the address flops double as the source-register latches.
          aaddr_d = IN_SRCA;
          baddr_d = IN_SRCB;
          state_d = S_READ;
        end
      end
      S_READ: begin
        opa_d   = Adata;
        opb_d   = Bdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Load the write-port and flag registers now so they are valid
        // for the whole WRITE cycle.
        ddata_d = alu_res;
        fz_d    = alu_z;
        fc_d    = alu_c;
        daddr_d = dst_q;
        wr_d    = is_wb(op_q);
        done_d  = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      op_q    <= OP_MOV;
      dst_q   <= '0;
      imm_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      aaddr_q <= '0;
      baddr_q <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      daddr_q <= '0;
      ddata_q <= '0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      aaddr_q <= aaddr_d;
      baddr_q <= baddr_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
    end
  end

  assign IN_READY = (state_q == S_IDLE);
  assign BUSY     = (state_q != S_IDLE);
  assign Aaddr    = aaddr_q;
  assign Baddr    = baddr_q;
  assign WR       = wr_q;
  assign DONE     = done_q;
  assign Daddr    = daddr_q;
  assign Ddata    = ddata_q;
  assign FLAG_Z   = fz_q;
  assign FLAG_C   = fc_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: directed bench for regfile_ctrl attached to a behavioural
// 4x4 register file. Expected write-port/flag values are pushed to a
// scoreboard when an instruction is driven and popped at DONE.
module tb_regfile_ctrl;
  import rfc_pkg::*;

  localparam int DW = 4;
  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          IN_VALID;
  logic          IN_READY;
  logic [2:0]    IN_OP;
  logic [AW-1:0] IN_DST, IN_SRCA, IN_SRCB;
  logic [DW-1:0] IN_IMM;
  logic [AW-1:0] Aaddr, Baddr, Daddr;
  logic [DW-1:0] Adata, Bdata, Ddata;
  logic          WR, BUSY, DONE, FLAG_Z, FLAG_C;

  always #5 CLK = ~CLK;

  regfile_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OP(IN_OP),
    .IN_DST(IN_DST), .IN_SRCA(IN_SRCA), .IN_SRCB(IN_SRCB), .IN_IMM(IN_IMM),
    .Aaddr(Aaddr), .Baddr(Baddr), .Adata(Adata), .Bdata(Bdata),
    .WR(WR), .Daddr(Daddr), .Ddata(Ddata),
    .BUSY(BUSY), .DONE(DONE), .FLAG_Z(FLAG_Z), .FLAG_C(FLAG_C)
  );

  // Register file: combinational read, write at the rising edge.
  logic [DW-1:0] rf [4] = '{default: '0};
  assign Adata = rf[Aaddr];
  assign Bdata = rf[Baddr];
  always @(posedge CLK) if (WR) rf[Daddr] <= Ddata;

  // Edge monitor: cycle count, accepted handshakes, write strobes.
  int cyc = 0;
  int acc_n = 0;
  int acc_cyc[$];
  int wr_cnt = 0;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RST_N && IN_VALID && IN_READY) begin
      acc_n <= acc_n + 1;
      acc_cyc.push_back(cyc);
    end
    if (WR) wr_cnt <= wr_cnt + 1;
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] da;
    logic [DW-1:0] d;
    logic          z;
    logic          c;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] sh [4] = '{default: '0};  // architectural shadow of rf
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour computed with plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [AW-1:0] dst,
                                 input logic [AW-1:0] sa, input logic [AW-1:0] sb_i,
                                 input logic [DW-1:0] imm);
    exp_t e;
    int a, b, r;
    a = int'(sh[sa]);
    b = int'(sh[sb_i]);
    r = 0;
    e.c = 1'b0;
    case (op)
      3'd0: r = a;
      3'd1: r = int'(imm);
      3'd2: begin r = a + b; e.c = (r > 15); end
      3'd3, 3'd7: begin r = a - b; e.c = (a < b); end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = 0;
    endcase
    r    = r & 15;
    e.d  = DW'(r);
    e.z  = (r == 0);
    e.wr = (op != 3'd7);
    e.da = dst;
    return e;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] sa,
                       input logic [AW-1:0] sbb, input logic [DW-1:0] imm, input bit push);
    exp_t e;
    IN_OP = op; IN_DST = dst; IN_SRCA = sa; IN_SRCB = sbb; IN_IMM = imm;
    IN_VALID = 1'b1;
    if (push) begin
      e = model(op, dst, sa, sbb, imm);
      sb.push_back(e);
      if (e.wr) sh[dst] = e.d;
    end
  endtask

  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic accept(input string tag);
    int n = 0;
    while (IN_READY !== 1'b1 && n < 10) begin @(negedge CLK); n++; end
    chk({tag, "_ready"}, 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
  endtask

  task automatic wait_done(input string tag, output int lat);
    bit   got = 0;
    exp_t e;
    lat = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge CLK);
      lat++;
      if (DONE === 1'b1) got = 1;
      else chk({tag, "_wr_quiet"}, 32'(WR), 32'd0);
    end
    if (!got) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    else if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else begin
      e = sb.pop_front();
      chk({tag, "_wr"},    32'(WR),     32'(e.wr));
      chk({tag, "_daddr"}, 32'(Daddr),  32'(e.da));
      if (e.wr) chk({tag, "_ddata"}, 32'(Ddata), 32'(e.d));
      chk({tag, "_z"},     32'(FLAG_Z), 32'(e.z));
      chk({tag, "_c"},     32'(FLAG_C), 32'(e.c));
    end
  endtask

  // Full single instruction; starts and ends at a falling edge in IDLE.
  task automatic run(input logic [2:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] sa,
                     input logic [AW-1:0] sbb, input logic [DW-1:0] imm, input string tag);
    int lat;
    drive(op, dst, sa, sbb, imm, 1'b1);
    accept(tag);
    IN_VALID = 1'b0;
    wait_done(tag, lat);
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    @(negedge CLK);
    chk({tag, "_ready_after"}, 32'(IN_READY), 32'd1);
  endtask

  task automatic chk_rf(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_rf%0d", tag, i), 32'(rf[i]), 32'(sh[i]));
  endtask

  int lat, a0, w0;

  initial begin
    IN_VALID = 1'b0; IN_OP = '0; IN_DST = '0; IN_SRCA = '0; IN_SRCB = '0; IN_IMM = '0;

    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_wr",    32'(WR),       32'd0);
    chk("rst_done",  32'(DONE),     32'd0);
    chk("rst_busy",  32'(BUSY),     32'd0);
    chk("rst_ready", 32'(IN_READY), 32'd1);
    chk("rst_aaddr", 32'(Aaddr),    32'd0);
    chk("rst_baddr", 32'(Baddr),    32'd0);
    chk("rst_daddr", 32'(Daddr),    32'd0);
    chk("rst_ddata", 32'(Ddata),    32'd0);
    chk("rst_z",     32'(FLAG_Z),   32'd0);
    chk("rst_c",     32'(FLAG_C),   32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // LDI R1,5 with cycle-level latency
    run(3'd1, 2'd1, 2'd0, 2'd0, 4'd5, "ldi_r1");
    chk("ldi_r1_val", 32'(rf[1]), 32'd5);

    // Arithmetic with carry / borrow
    run(3'd1, 2'd2, 2'd0, 2'd0, 4'd12, "ldi_r2");
    run(3'd2, 2'd3, 2'd1, 2'd2, 4'd0, "add_r3");
    chk("add_r3_val", 32'(rf[3]), 32'd1);
    chk("add_hold_c", 32'(FLAG_C), 32'd1);
    chk("add_hold_z", 32'(FLAG_Z), 32'd0);
    run(3'd3, 2'd0, 2'd1, 2'd2, 4'd0, "sub_r0");
    chk("sub_r0_val", 32'(rf[0]), 32'd9);
    chk("sub_hold_c", 32'(FLAG_C), 32'd1);

    // CMP: flags only, no write
    w0 = wr_cnt;
    run(3'd7, 2'd1, 2'd1, 2'd1, 4'd0, "cmp_r1");
    chk("cmp_no_wr", 32'(wr_cnt), 32'(w0));
    chk("cmp_z", 32'(FLAG_Z), 32'd1);
    chk("cmp_c", 32'(FLAG_C), 32'd0);
    chk_rf("cmp");

    // Back-to-back with IN_VALID held high throughout
    a0 = acc_n;
    drive(3'd1, 2'd0, 2'd0, 2'd0, 4'd7, 1'b1);
    accept("b2b1");
    drive(3'd2, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1);
    wait_done("b2b1", lat);
    chk("b2b1_latency", 32'(lat), 32'd3);
    wait_done("b2b2", lat);
    chk("b2b2_latency", 32'(lat), 32'd4);
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("b2b_accepts", 32'(acc_n - a0), 32'd2);
    if (acc_cyc.size() >= 2)
      chk("b2b_gap", 32'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 32'd4);
    else
      chk("b2b_gap_missing", 32'(acc_cyc.size()), 32'd2);
    chk("b2b_r0_val", 32'(rf[0]), 32'd14);

    // Logic ops
    run(3'd6, 2'd2, 2'd2, 2'd2, 4'd0, "xor_r2");
    chk("xor_r2_val", 32'(rf[2]), 32'd0);
    chk("xor_z", 32'(FLAG_Z), 32'd1);
    run(3'd1, 2'd1, 2'd0, 2'd0, 4'hA, "ldi_a");
    run(3'd1, 2'd3, 2'd0, 2'd0, 4'h6, "ldi_6");
    run(3'd4, 2'd0, 2'd1, 2'd3, 4'd0, "and_op");
    chk("and_val", 32'(rf[0]), 32'h2);
    run(3'd5, 2'd0, 2'd1, 2'd3, 4'd0, "or_op");
    chk("or_val", 32'(rf[0]), 32'hE);
    chk_rf("logic");

    // Reset while in EXEC drops the instruction
    run(3'd1, 2'd2, 2'd0, 2'd0, 4'd12, "ldi_r2b");
    w0 = wr_cnt;
    drive(3'd2, 2'd2, 2'd2, 2'd2, 4'd0, 1'b0);
    accept("abort");
    IN_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_busy_exec", 32'(BUSY), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("abort_ready", 32'(IN_READY), 32'd1);
    chk("abort_busy",  32'(BUSY),     32'd0);
    chk("abort_wr",    32'(WR),       32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("abort_no_wr", 32'(wr_cnt), 32'(w0));
    chk("abort_r2",    32'(rf[2]),  32'd12);
    run(3'd1, 2'd3, 2'd0, 2'd0, 4'd3, "post_rst_ldi");
    chk("post_rst_r3", 32'(rf[3]), 32'd3);
    chk_rf("final");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
